// File: rtl/vga_pattern_pkg.sv
// Shared definitions for the VGA test-pattern stage: geometry, mode encodings
// and the colour palette used by the pattern mux.
package vga_pattern_pkg;

    localparam int H_ACTIVE   = 1920;
    localparam int V_ACTIVE   = 1080;
    localparam int BAR_W      = 240;
    localparam int CHK_SHIFT  = 6;
    localparam int GRID_SHIFT = 7;
    localparam int BOX_SIZE   = 64;
    localparam int BOX_STEP   = 4;

    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_GRID    = 2'd2,
        MODE_BOX     = 2'd3
    } mode_e;

    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_BLACK   = 24'h000000;
    localparam logic [23:0] RGB_GRID_BG = 24'h000040;
    localparam logic [23:0] RGB_BOX_BG  = 24'h404040;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_pattern_if.sv
// Upstream timing bundle from the sync generator: active flag, syncs and pixel address.
interface vga_pattern_if;
    logic        Ready_Sig;
    logic        HSYNC_Sig;
    logic        VSYNC_Sig;
    logic [10:0] Column_Addr_Sig;
    logic [10:0] Row_Addr_Sig;

    modport master (output Ready_Sig, HSYNC_Sig, VSYNC_Sig, Column_Addr_Sig, Row_Addr_Sig);
    modport slave  (input  Ready_Sig, HSYNC_Sig, VSYNC_Sig, Column_Addr_Sig, Row_Addr_Sig);
endinterface

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing box: moves STEP px per enabled frame and reverses
// direction, clamped to the edge, when it would leave [0, LIMIT-SIZE].
module vga_bounce_axis #(
    parameter int LIMIT = 1920,
    parameter int SIZE  = 64,
    parameter int STEP  = 4
) (
    input  logic        vga_clk,
    input  logic        rst_n,
    input  logic        step_en,
    output logic [10:0] pos
);

    localparam logic [11:0] POS_MAX = 12'(LIMIT - SIZE);
    localparam logic [11:0] STEP_W  = 12'(STEP);

    logic [10:0] pos_q, pos_d;
    logic        dir_neg_q, dir_neg_d;
    logic [11:0] pos_w, pos_up_s;

    assign pos_w    = {1'b0, pos_q};
    assign pos_up_s = pos_w + STEP_W;

    // Next position and direction for this frame step
    always_comb begin
        pos_d     = pos_q;
        dir_neg_d = dir_neg_q;
        if (!step_en) begin
            pos_d = pos_q;
        end else if (!dir_neg_q) begin
            if (pos_up_s > POS_MAX) begin
                pos_d     = POS_MAX[10:0];
                dir_neg_d = 1'b1;
            end else begin
                pos_d = pos_up_s[10:0];
            end
        end else begin
            if (pos_w < STEP_W) begin
                pos_d     = 11'd0;
                dir_neg_d = 1'b0;
            end else begin
                pos_d = 11'(pos_w - STEP_W);
            end
        end
    end

    // Position and direction state
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q     <= 11'd0;
            dir_neg_q <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            dir_neg_q <= dir_neg_d;
        end
    end

    assign pos = pos_q;

endmodule

// File: rtl/vga_pattern_gen_module.sv
// Pixel stage behind the 1080p sync generator: two-stage pipeline producing
// registered RGB for four test patterns, with syncs/DE delayed to match.
module vga_pattern_gen_module
    import vga_pattern_pkg::*;
(
    input  logic         vga_clk,
    input  logic         rst_n,
    input  logic         mode_next_i,
    vga_pattern_if.slave tmg,
    output logic [7:0]   VGA_RED,
    output logic [7:0]   VGA_GREEN,
    output logic [7:0]   VGA_BLUE,
    output logic         VGA_HSYNC,
    output logic         VGA_VSYNC,
    output logic         VGA_DE,
    output logic [1:0]   mode_o
);

    logic        ready_q, ready_d, hs_q, hs_d, vs_q, vs_d;
    logic [10:0] col_q, col_d, row_q, row_d;
    logic        vs_prev_q, vs_prev_d, pending_q, pending_d;
    mode_e       mode_q, mode_d;
    logic [23:0] rgb_q, rgb_d;
    logic        hs_out_q, hs_out_d, vs_out_q, vs_out_d, de_q, de_d;

    logic        vs_fall_s, box_step_s, in_box_s, on_grid_s;
    logic [10:0] box_x_s, box_y_s;
    logic [11:0] col_w, row_w, bx_w, by_w;
    logic [2:0]  bar_idx_s;

    assign vs_fall_s  = vs_prev_q & ~tmg.VSYNC_Sig;
    // Box moves on the pre-change mode so the frame that leaves BOX still steps it
    assign box_step_s = vs_fall_s & (mode_q == MODE_BOX);

    vga_bounce_axis #(.LIMIT(H_ACTIVE), .SIZE(BOX_SIZE), .STEP(BOX_STEP)) u_axis_x (
        .vga_clk(vga_clk), .rst_n(rst_n), .step_en(box_step_s), .pos(box_x_s)
    );

    vga_bounce_axis #(.LIMIT(V_ACTIVE), .SIZE(BOX_SIZE), .STEP(BOX_STEP)) u_axis_y (
        .vga_clk(vga_clk), .rst_n(rst_n), .step_en(box_step_s), .pos(box_y_s)
    );

    // Input capture and frame-boundary mode stepping
    always_comb begin
        ready_d   = tmg.Ready_Sig;
        hs_d      = tmg.HSYNC_Sig;
        vs_d      = tmg.VSYNC_Sig;
        col_d     = tmg.Column_Addr_Sig;
        row_d     = tmg.Row_Addr_Sig;
        vs_prev_d = tmg.VSYNC_Sig;
        mode_d    = mode_q;
        pending_d = pending_q;
        if (vs_fall_s) begin
            mode_d    = mode_e'(mode_q + {1'b0, pending_q | mode_next_i});
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q | mode_next_i;
        end
    end

    assign col_w = {1'b0, col_q};
    assign row_w = {1'b0, row_q};
    assign bx_w  = {1'b0, box_x_s};
    assign by_w  = {1'b0, box_y_s};

    // Pattern mux on stage-1 data
    always_comb begin
        bar_idx_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            bar_idx_s = bar_idx_s + ((col_w >= 12'(k * BAR_W)) ? 3'd1 : 3'd0);
        end
        in_box_s  = (col_w >= bx_w) && (col_w < bx_w + 12'(BOX_SIZE)) &&
                    (row_w >= by_w) && (row_w < by_w + 12'(BOX_SIZE));
        on_grid_s = (col_q[GRID_SHIFT-1:0] == {GRID_SHIFT{1'b0}}) ||
                    (row_q[GRID_SHIFT-1:0] == {GRID_SHIFT{1'b0}}) ||
                    (col_q == 11'(H_ACTIVE - 1)) || (row_q == 11'(V_ACTIVE - 1));
        rgb_d     = RGB_BLACK;
        if (!ready_q) begin
            rgb_d = RGB_BLACK;
        end else begin
            case (mode_q)
                MODE_BARS:    rgb_d = bar_colour(bar_idx_s);
                MODE_CHECKER: rgb_d = (col_q[CHK_SHIFT] ^ row_q[CHK_SHIFT]) ? RGB_WHITE : RGB_BLACK;
                MODE_GRID:    rgb_d = on_grid_s ? RGB_WHITE : RGB_GRID_BG;
                MODE_BOX:     rgb_d = in_box_s ? RGB_RED : RGB_BOX_BG;
                default:      rgb_d = RGB_BLACK;
            endcase
        end
        hs_out_d = hs_q;
        vs_out_d = vs_q;
        de_d     = ready_q;
    end

    // Pipeline, mode and pending-request state
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q   <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            col_q     <= 11'd0;
            row_q     <= 11'd0;
            vs_prev_q <= 1'b0;
            mode_q    <= MODE_BARS;
            pending_q <= 1'b0;
            rgb_q     <= 24'd0;
            hs_out_q  <= 1'b1;
            vs_out_q  <= 1'b1;
            de_q      <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            col_q     <= col_d;
            row_q     <= row_d;
            vs_prev_q <= vs_prev_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            rgb_q     <= rgb_d;
            hs_out_q  <= hs_out_d;
            vs_out_q  <= vs_out_d;
            de_q      <= de_d;
        end
    end

    assign VGA_RED   = rgb_q[23:16];
    assign VGA_GREEN = rgb_q[15:8];
    assign VGA_BLUE  = rgb_q[7:0];
    assign VGA_HSYNC = hs_out_q;
    assign VGA_VSYNC = vs_out_q;
    assign VGA_DE    = de_q;
    assign mode_o    = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen_module.sv
// Randomized bench for vga_pattern_gen_module against an arithmetic reference model.
module tb_vga_pattern_gen_module;

    logic       vga_clk = 1'b0;
    logic       rst_n;
    logic       mode_next;
    logic [7:0] red, green, blue;
    logic       hs_o, vs_o, de_o;
    logic [1:0] mode_o;

    vga_pattern_if tmg();

    vga_pattern_gen_module dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .mode_next_i(mode_next), .tmg(tmg),
        .VGA_RED(red), .VGA_GREEN(green), .VGA_BLUE(blue),
        .VGA_HSYNC(hs_o), .VGA_VSYNC(vs_o), .VGA_DE(de_o), .mode_o(mode_o)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        logic [23:0] rgb;
        logic        hs, vs, de;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_mode, m_pend, m_vsprev, m_bx, m_by, m_dx, m_dy;
    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pend = 0; m_vsprev = 0;
        m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
        exp_q.delete();
    endtask

    task automatic axis_step(inout int pos, inout int dir, input int lim);
        if (dir > 0) begin
            if (pos + 4 > lim - 64) begin pos = lim - 64; dir = -1; end
            else pos = pos + 4;
        end else begin
            if (pos < 4) begin pos = 0; dir = 1; end
            else pos = pos - 4;
        end
    endtask

    function automatic logic [23:0] model_rgb(input bit rdy, input int col, input int row);
        int idx;
        if (!rdy) return 24'h000000;
        case (m_mode)
            0: begin
                idx = col / 240;
                if (idx > 7) idx = 7;
                return bar_tab[idx];
            end
            1: return ((((col / 64) ^ (row / 64)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
            2: return (col % 128 == 0 || row % 128 == 0 || col == 1919 || row == 1079)
                      ? 24'hFFFFFF : 24'h000040;
            default: return (col >= m_bx && col < m_bx + 64 && row >= m_by && row < m_by + 64)
                            ? 24'hFF0000 : 24'h404040;
        endcase
    endfunction

    function automatic int clampi(input int v);
        return (v < 0) ? 0 : (v > 2047) ? 2047 : v;
    endfunction

    // One pixel-clock cycle: apply inputs, advance the model, compare outputs due now
    task automatic drive(input bit rdy, input bit hs, input bit vs, input int col, input int row,
                         input bit pulse);
        exp_t e;
        tmg.Ready_Sig       = rdy;
        tmg.HSYNC_Sig       = hs;
        tmg.VSYNC_Sig       = vs;
        tmg.Column_Addr_Sig = 11'(col);
        tmg.Row_Addr_Sig    = 11'(row);
        mode_next           = pulse;
        if (m_vsprev == 1 && !vs) begin
            if (m_mode == 3) begin
                axis_step(m_bx, m_dx, 1920);
                axis_step(m_by, m_dy, 1080);
            end
            if (m_pend == 1 || pulse) m_mode = (m_mode + 1) % 4;
            m_pend = 0;
        end else if (pulse) begin
            m_pend = 1;
        end
        m_vsprev = vs ? 1 : 0;
        e.rgb = model_rgb(rdy, col, row);
        e.hs = hs; e.vs = vs; e.de = rdy;
        exp_q.push_back(e);
        @(posedge vga_clk); #1;
        check_eq("mode", 32'(mode_o), 32'(m_mode));
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            check_eq("rgb", {8'd0, red, green, blue}, {8'd0, e.rgb});
            check_eq("hsync", 32'(hs_o), 32'(e.hs));
            check_eq("vsync", 32'(vs_o), 32'(e.vs));
            check_eq("de", 32'(de_o), 32'(e.de));
        end
    endtask

    task automatic advance();
        drive(1'b1, 1'b1, 1'b1, 0, 0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_rgb"}, {8'd0, red, green, blue}, 32'd0);
        check_eq({tag, "_de"}, 32'(de_o), 32'd0);
        check_eq({tag, "_hs"}, 32'(hs_o), 32'd1);
        check_eq({tag, "_vs"}, 32'(vs_o), 32'd1);
        check_eq({tag, "_mode"}, 32'(mode_o), 32'd0);
    endtask

    initial begin
        int offs [4] = '{-1, 0, 63, 64};
        rst_n = 1'b0;
        mode_next = 1'b0;
        tmg.Ready_Sig = 1'b1; tmg.HSYNC_Sig = 1'b0; tmg.VSYNC_Sig = 1'b0;
        tmg.Column_Addr_Sig = 11'd5; tmg.Row_Addr_Sig = 11'd5;
        model_reset();

        // Reset held with live-looking inputs
        repeat (4) begin
            @(posedge vga_clk); #1;
            tmg.Column_Addr_Sig = 11'($urandom_range(0, 2047));
            mode_next = 1'($urandom_range(0, 1));
        end
        check_reset_state("rst_hold");
        rst_n = 1'b1;
        model_reset();
        drive(1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        check_eq("rel_rgb", {8'd0, red, green, blue}, 32'd0);
        check_eq("rel_de", 32'(de_o), 32'd0);
        repeat (3) drive(1'b0, 1'b1, 1'b1, $urandom_range(0, 1919), 0, 1'b0);

        // Colour bars, including the bar edges
        drive(1'b1, 1'b1, 1'b1, 0, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 240, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1679, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1680, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 239, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1919, 0, 1'b0);
        repeat (20) drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 2047), 0, 1'b0);

        // Two pulses in one frame give one step at the boundary
        drive(1'b1, 1'b1, 1'b1, 10, 0, 1'b1);
        repeat (3) drive(1'b1, 1'b1, 1'b1, 10, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 10, 0, 1'b1);
        repeat (3) drive(1'b1, 1'b1, 1'b1, 10, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 10, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 10, 0, 1'b0);
        // Pulse landing on the boundary cycle itself
        drive(1'b1, 1'b1, 1'b1, 10, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 10, 0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 10, 0, 1'b0);
        advance();
        advance();
        // Checkerboard
        advance();
        drive(1'b1, 1'b1, 1'b1, 64, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 64, 64, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 0, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 63, 64, 1'b0);
        repeat (16) drive(1'b1, 1'b1, 1'b1, $urandom_range(0, 1919), $urandom_range(0, 1079), 1'b0);
        // Grid, including the last column and row
        advance();
        drive(1'b1, 1'b1, 1'b1, 1919, 5, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1918, 5, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 128, 7, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 3, 1079, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 3, 256, 1'b0);
        repeat (16) drive(1'b1, 1'b1, 1'b1, $urandom_range(0, 1919), $urandom_range(0, 1079), 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1919, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1919, 0, 1'b0);

        // Reset in the middle of a frame takes effect immediately
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_rst");
        @(posedge vga_clk); #1;
        rst_n = 1'b1;
        model_reset();
        repeat (4) drive(1'b1, 1'b1, 1'b1, $urandom_range(0, 1919), 0, 1'b0);

        // Bouncing box: probe the box corners every frame across both bounces
        repeat (3) advance();
        for (int f = 0; f < 540; f++) begin
            for (int p = 0; p < 4; p++) begin
                drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, clampi(m_bx + offs[p]),
                      clampi(m_by + offs[$urandom_range(0, 3)]), 1'b0);
            end
            drive(1'($urandom_range(0, 1)), 1'b1, 1'b0, $urandom_range(0, 1919),
                  $urandom_range(0, 1079), 1'b0);
        end
        // Leave BOX, run frames elsewhere, come back: position held
        advance();
        repeat (5) begin
            drive(1'b1, 1'b1, 1'b1, $urandom_range(0, 1919), $urandom_range(0, 1079), 1'b0);
            drive(1'b1, 1'b1, 1'b0, $urandom_range(0, 1919), $urandom_range(0, 1079), 1'b0);
        end
        repeat (3) advance();
        for (int p = 0; p < 4; p++) begin
            drive(1'b1, 1'b1, 1'b1, clampi(m_bx + offs[p]), clampi(m_by + offs[p]), 1'b0);
        end

        // Free-running random syncs, ready and mode requests
        for (int i = 0; i < 4000; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) != 0), $urandom_range(0, 2047),
                  $urandom_range(0, 2047), ($urandom_range(0, 5) == 0));
        end
        drive(1'b0, 1'b1, 1'b1, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
